// File: rtl/image_pipe_ctrl.sv
// Frame sequencer ahead of the greyscale/convolution pipeline.
// Arms on enable, syncs to SOF, regenerates X/Y, reports completion.
module image_pipe_ctrl #(
  parameter int IMG_W     = 640,
  parameter int IMG_H     = 480,
  parameter int DRAIN_CYC = 1300,
  parameter int CNT_W     = 20
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iEnable,
  input  logic             iFVAL,
  input  logic             iDVAL,
  input  logic [11:0]      iDATA,
  input  logic             iMode_sw,
  input  logic             iProc_valid,
  output logic [11:0]      oDATA,
  output logic             oDVAL,
  output logic [10:0]      oX_Cont,
  output logic [10:0]      oY_Cont,
  output logic             oMode,
  output logic             oBusy,
  output logic             oFrame_done,
  output logic [CNT_W-1:0] oProc_cnt,
  output logic             oErr
);

  localparam int DW = $clog2(DRAIN_CYC + 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SOF,
    ACTIVE,
    DRAIN
  } state_t;

  state_t           state_q, state_d;
  logic             fval_q;
  logic [10:0]      x_q, x_d;
  logic [10:0]      y_q, y_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic [CNT_W-1:0] proc_q, proc_d;
  logic [CNT_W-1:0] proc_cnt_q, proc_cnt_d;
  logic [11:0]      data_q, data_d;
  logic             dval_q, dval_d;
  logic [10:0]      ox_q, ox_d;
  logic [10:0]      oy_q, oy_d;
  logic             mode_q, mode_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             rise;
  logic             x_end;
  logic             last_px;
  logic [CNT_W-1:0] proc_sat;

  assign rise     = iFVAL & ~fval_q;
  assign x_end    = (x_q == 11'(IMG_W - 1));
  assign last_px  = x_end && (y_q == 11'(IMG_H - 1));
  assign proc_sat = (proc_q == '1) ? proc_q : proc_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    drain_d    = drain_q;
    proc_d     = proc_q;
    proc_cnt_d = proc_cnt_q;
    data_d     = data_q;
    dval_d     = 1'b0;
    ox_d       = ox_q;
    oy_d       = oy_q;
    mode_d     = mode_q;
    done_d     = 1'b0;
    err_d      = err_q;
    unique case (state_q)
      IDLE: begin
        if (iEnable) begin
          state_d = WAIT_SOF;
          err_d   = 1'b0;
        end
      end
      WAIT_SOF: begin
        if (rise) begin
          mode_d  = iMode_sw;
          x_d     = '0;
          y_d     = '0;
          proc_d  = '0;
          state_d = ACTIVE;
        end else if (!iEnable) begin
          state_d = IDLE;
        end
      end
      ACTIVE: begin
        if (iProc_valid) proc_d = proc_sat;
        if (iDVAL) begin
          data_d = iDATA;
          dval_d = 1'b1;
          ox_d   = x_q;
          oy_d   = y_q;
          if (x_end) begin
            x_d = '0;
            y_d = y_q + 11'd1;
          end else begin
            x_d = x_q + 11'd1;
          end
        end
        // a pixel on the falling-FVAL cycle still counts
        if (iDVAL && last_px) begin
          state_d = DRAIN;
          drain_d = '0;
        end else if (!iFVAL) begin
          err_d   = 1'b1;
          state_d = DRAIN;
          drain_d = '0;
        end
      end
      DRAIN: begin
        if (iProc_valid) proc_d = proc_sat;
        drain_d = drain_q + 1'b1;
        if (drain_q == DW'(DRAIN_CYC - 1)) begin
          done_d     = 1'b1;
          proc_cnt_d = iProc_valid ? proc_sat : proc_q;
          state_d    = iEnable ? WAIT_SOF : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q    <= IDLE;
      fval_q     <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      drain_q    <= '0;
      proc_q     <= '0;
      proc_cnt_q <= '0;
      data_q     <= '0;
      dval_q     <= 1'b0;
      ox_q       <= '0;
      oy_q       <= '0;
      mode_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fval_q     <= iFVAL;
      x_q        <= x_d;
      y_q        <= y_d;
      drain_q    <= drain_d;
      proc_q     <= proc_d;
      proc_cnt_q <= proc_cnt_d;
      data_q     <= data_d;
      dval_q     <= dval_d;
      ox_q       <= ox_d;
      oy_q       <= oy_d;
      mode_q     <= mode_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign oDATA       = data_q;
  assign oDVAL       = dval_q;
  assign oX_Cont     = ox_q;
  assign oY_Cont     = oy_q;
  assign oMode       = mode_q;
  assign oBusy       = busy_q;
  assign oFrame_done = done_q;
  assign oProc_cnt   = proc_cnt_q;
  assign oErr        = err_q;

endmodule

// File: tb/tb_image_pipe_ctrl.sv
// Bench for image_pipe_ctrl: randomized frames against a
// frame-level reference model (pixel index -> x/y, counts, flags).
module tb_image_pipe_ctrl;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int DC = 5;
  localparam int CW = 20;

  logic          iCLK = 1'b0;
  logic          iRST;
  logic          iEnable;
  logic          iFVAL;
  logic          iDVAL;
  logic [11:0]   iDATA;
  logic          iMode_sw;
  logic          iProc_valid;
  logic [11:0]   oDATA;
  logic          oDVAL;
  logic [10:0]   oX_Cont;
  logic [10:0]   oY_Cont;
  logic          oMode;
  logic          oBusy;
  logic          oFrame_done;
  logic [CW-1:0] oProc_cnt;
  logic          oErr;

  image_pipe_ctrl #(
    .IMG_W(W),
    .IMG_H(H),
    .DRAIN_CYC(DC),
    .CNT_W(CW)
  ) dut (
    .iCLK(iCLK),
    .iRST(iRST),
    .iEnable(iEnable),
    .iFVAL(iFVAL),
    .iDVAL(iDVAL),
    .iDATA(iDATA),
    .iMode_sw(iMode_sw),
    .iProc_valid(iProc_valid),
    .oDATA(oDATA),
    .oDVAL(oDVAL),
    .oX_Cont(oX_Cont),
    .oY_Cont(oY_Cont),
    .oMode(oMode),
    .oBusy(oBusy),
    .oFrame_done(oFrame_done),
    .oProc_cnt(oProc_cnt),
    .oErr(oErr)
  );

  always #5 iCLK = ~iCLK;

  int checks = 0;
  int fails  = 0;

  // expected outputs
  logic          dval_exp;
  logic [11:0]   data_exp;
  logic [10:0]   x_exp;
  logic [10:0]   y_exp;
  logic          mode_exp;
  logic          busy_exp;
  logic          done_exp;
  logic [CW-1:0] cnt_exp;
  logic          err_exp;
  bit            armed;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".dval"}, 32'(oDVAL), 32'(dval_exp));
    chk({tag, ".data"}, 32'(oDATA), 32'(data_exp));
    chk({tag, ".x"}, 32'(oX_Cont), 32'(x_exp));
    chk({tag, ".y"}, 32'(oY_Cont), 32'(y_exp));
    chk({tag, ".mode"}, 32'(oMode), 32'(mode_exp));
    chk({tag, ".busy"}, 32'(oBusy), 32'(busy_exp));
    chk({tag, ".done"}, 32'(oFrame_done), 32'(done_exp));
    chk({tag, ".cnt"}, 32'(oProc_cnt), 32'(cnt_exp));
    chk({tag, ".err"}, 32'(oErr), 32'(err_exp));
  endtask

  task automatic step();
    @(posedge iCLK);
    #1;
  endtask

  task automatic do_reset();
    iRST  = 1'b1;
    iDVAL = 1'b1;
    step();
    iRST     = 1'b0;
    armed    = 1'b0;
    dval_exp = 1'b0;
    data_exp = '0;
    x_exp    = '0;
    y_exp    = '0;
    mode_exp = 1'b0;
    busy_exp = 1'b0;
    done_exp = 1'b0;
    cnt_exp  = '0;
    err_exp  = 1'b0;
    check_all("reset");
  endtask

  // Cycles outside a frame: pixels must be dropped, arming follows iEnable.
  task automatic idle(input int n, input bit fval, input bit en);
    repeat (n) begin
      iFVAL       = fval;
      iEnable     = en;
      iDVAL       = 1'($urandom);
      iDATA       = 12'($urandom);
      iProc_valid = 1'($urandom);
      step();
      if (!armed && en) begin
        armed   = 1'b1;
        err_exp = 1'b0;
      end else if (armed && !en) begin
        armed = 1'b0;
      end
      dval_exp = 1'b0;
      done_exp = 1'b0;
      busy_exp = armed;
      check_all("idle");
    end
  endtask

  // One frame from SOF; caller leaves the DUT armed with iFVAL low.
  // short_n>0: FVAL drops after short_n pixels (that cycle carries one more).
  task automatic frame(input int short_n, input bit mode, input bit toggle,
                       input bit en_end, input bit rise_in_drain,
                       input int rst_after);
    int          k;
    int          lim;
    longint      proc;
    bit          acc;
    logic [11:0] d;
    iFVAL       = 1'b1;
    iEnable     = 1'b1;
    iMode_sw    = mode;
    iDVAL       = 1'($urandom);
    iDATA       = 12'($urandom);
    iProc_valid = 1'($urandom);
    step();
    mode_exp = mode;
    busy_exp = 1'b1;
    dval_exp = 1'b0;
    done_exp = 1'b0;
    check_all("sof");
    k    = 0;
    proc = 0;
    lim  = (short_n > 0) ? short_n : W * H;
    while (k < lim) begin
      if (rst_after > 0 && k == rst_after) begin
        do_reset();
        return;
      end
      acc         = ($urandom % 4) != 0;
      d           = 12'($urandom);
      iDVAL       = acc;
      iDATA       = d;
      iProc_valid = 1'($urandom);
      if (toggle && k == lim / 2) iMode_sw = ~mode;
      if (k == 2) iEnable = en_end;
      proc += iProc_valid;
      step();
      dval_exp = acc;
      if (acc) begin
        data_exp = d;
        x_exp    = 11'(k % W);
        y_exp    = 11'(k / W);
        k++;
      end
      check_all("act");
    end
    if (short_n > 0) begin
      d           = 12'($urandom);
      iFVAL       = 1'b0;
      iDVAL       = 1'b1;
      iDATA       = d;
      iProc_valid = 1'($urandom);
      proc += iProc_valid;
      step();
      err_exp  = 1'b1;
      dval_exp = 1'b1;
      data_exp = d;
      x_exp    = 11'(k % W);
      y_exp    = 11'(k / W);
      check_all("short");
    end
    for (int c = 1; c <= DC; c++) begin
      iFVAL       = rise_in_drain && c >= 2;
      iDVAL       = 1'($urandom);
      iDATA       = 12'($urandom);
      iProc_valid = 1'($urandom);
      proc += iProc_valid;
      step();
      dval_exp = 1'b0;
      if (c == DC) begin
        done_exp = 1'b1;
        cnt_exp  = (proc > longint'((1 << CW) - 1)) ?
                   CW'((1 << CW) - 1) : CW'(proc);
        busy_exp = en_end;
        armed    = en_end;
      end
      check_all("drain");
    end
  endtask

  initial begin
    iRST        = 1'b1;
    iEnable     = 1'b0;
    iFVAL       = 1'b0;
    iDVAL       = 1'b0;
    iDATA       = '0;
    iMode_sw    = 1'b0;
    iProc_valid = 1'b0;
    armed       = 1'b0;
    do_reset();
    idle(3, 1'b0, 1'b0);
    idle(2, 1'b0, 1'b1);
    // nominal frame with mid-frame mode toggle
    frame(0, 1'b0, 1'b1, 1'b1, 1'b0, 0);
    frame(0, 1'b1, 1'b0, 1'b1, 1'b0, 0);
    idle(2, 1'b0, 1'b1);
    // short frame, plus an FVAL rise inside DRAIN
    frame(7, 1'b0, 1'b1, 1'b1, 1'b1, 0);
    idle(3, 1'b1, 1'b1);
    idle(1, 1'b0, 1'b1);
    // good frame keeps err; stop request mid-frame
    frame(0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    idle(3, 1'b0, 1'b0);
    // late arm while a frame is in progress
    idle(2, 1'b1, 1'b0);
    idle(3, 1'b1, 1'b1);
    idle(1, 1'b0, 1'b1);
    frame(0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    // reset in the middle of a frame
    frame(0, 1'b1, 1'b0, 1'b1, 1'b0, 5);
    idle(4, 1'b1, 1'b0);
    idle(2, 1'b0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/image_pipe_ctrl.md
Name: image_pipe_ctrl

Overview:
- Frame-level sequencer in front of the greyscale/convolution pipeline.
- Arms on a software enable and synchronises to sensor start-of-frame.
- Regenerates clean X/Y pixel coordinates and gates pixel valid to exactly one frame.
- Latches the vertical/horizontal filter select so it only changes between frames, waits for the pipeline to drain, then reports frame completion, processed-pixel count and short-frame errors.

Parameters:
- IMG_W, 640, active pixels per line (X wraps at IMG_W-1).
- IMG_H, 480, active lines per frame.
- DRAIN_CYC, 1300, cycles spent in DRAIN after the last accepted pixel; must exceed the pipeline latency, which is two lines plus margin.
- CNT_W, 20, width of the processed-pixel counter.

Ports:
- iCLK, in, 1, system clock.
- iRST, in, 1, synchronous active-high reset.
- iEnable, in, 1, level; 1 = capture frames continuously, 0 = stop after the current frame.
- iFVAL, in, 1, sensor frame valid.
- iDVAL, in, 1, sensor pixel valid.
- iDATA, in, 12, sensor pixel.
- iMode_sw, in, 1, filter select request (0 vertical, 1 horizontal).
- iProc_valid, in, 1, valid strobe from the convolution output.
- oDATA, out, 12, registered pixel to the pipeline.
- oDVAL, out, 1, gated pixel valid to the pipeline.
- oX_Cont, out, 11, X of the pixel on oDATA.
- oY_Cont, out, 11, Y of the pixel on oDATA.
- oMode, out, 1, filter select to the pipeline, frame-stable.
- oBusy, out, 1, 1 in WAIT_SOF/ACTIVE/DRAIN.
- oFrame_done, out, 1, one-cycle pulse at the end of DRAIN.
- oProc_cnt, out, CNT_W, count of iProc_valid in the last completed frame.
- oErr, out, 1, sticky short-frame flag.

Behaviour:
- Reset (iRST=1 at a clock edge, any state):
  - State goes to IDLE.
  - Every output is 0, and every internal counter is 0.
  - The iFVAL edge-detect register is 0.
  - Reset mid-frame abandons the frame immediately.
- iFVAL rising edge (rise): iFVAL=1 and the registered previous iFVAL=0.
- States:
  - IDLE: oBusy=0. If iEnable=1 → WAIT_SOF, clear oErr.
  - WAIT_SOF: wait for rise. A frame already in progress when WAIT_SOF is entered is skipped. On rise: oMode<=iMode_sw, x=y=0, proc counter=0 → ACTIVE. If iEnable=0 → IDLE.
  - ACTIVE:
    - Each cycle with iDVAL=1, the pixel is accepted.
    - Next cycle: oDATA=iDATA, oDVAL=1, oX_Cont=x, oY_Cont=y. Latency is 1 cycle; otherwise oDVAL=0 and oDATA/oX/oY hold.
    - x increments and wraps to 0 at IMG_W-1, with y incrementing on the wrap.
    - Acceptance of pixel (IMG_W-1, IMG_H-1) → DRAIN, drain counter=0.
    - If iFVAL falls before the last pixel: set oErr, → DRAIN. The pixel on that cycle is accepted if iDVAL=1.
    - iEnable is ignored in ACTIVE.
  - DRAIN:
    - No pixels are accepted (oDVAL=0 after the final forwarded pixel).
    - The drain counter increments every cycle.
    - When it equals DRAIN_CYC-1: oFrame_done=1 for one cycle, oProc_cnt<=proc counter (including any iProc_valid on that cycle); then → WAIT_SOF if iEnable=1, else IDLE.
    - A rise during DRAIN is not a valid SOF. That frame is skipped, because WAIT_SOF only sees rises occurring while in it.
- iProc_valid counting:
  - Counted in ACTIVE and DRAIN only.
  - Saturates at 2^CNT_W-1.
  - Ignored in IDLE/WAIT_SOF.
- iDVAL outside ACTIVE is dropped, with oDVAL=0.
- oMode changes only on a WAIT_SOF→ACTIVE transition. Toggling iMode_sw mid-frame has no effect until the next SOF.
- oErr is cleared only by iRST or by the IDLE→WAIT_SOF transition; it is not cleared between consecutive frames.
- Widths: x/y are 11-bit; IMG_W and IMG_H must be ≤ 2047.

Test Plan:
Parameters for all scenarios: IMG_W=4, IMG_H=3, DRAIN_CYC=5.
- Nominal frame: iEnable=1, rise, 12 iDVAL pixels with data 0..11 → oDVAL pulses with (x,y) = (0,0)…(3,0),(0,1)…(3,2), oDATA=0..11, each 1 cycle after the input. oFrame_done pulses 5 cycles after the last accept. oErr=0.
- Mode latching: iMode_sw=0 at SOF, toggled to 1 mid-frame → oMode stays 0 for the whole frame and becomes 1 only at the next SOF.
- Short frame: iFVAL drops after 7 pixels → oErr=1, DRAIN entered, oFrame_done after 5 cycles. oErr stays 1 through the next good frame and clears only after iEnable 0→1 via IDLE.
- Proc count: 9 iProc_valid pulses spread over ACTIVE+DRAIN, plus 2 in WAIT_SOF → oProc_cnt=9 at oFrame_done.
- Late arm / stop: arm while iFVAL=1 → no pixels forwarded until the next rise. Deassert iEnable during ACTIVE → the frame completes, then state is IDLE and oBusy=0.
- Reset mid-frame: iRST=1 after pixel 5 → next cycle all outputs 0 and state IDLE. Subsequent iDVAL is ignored.
